// File: rtl/id_ex_elastic_reg_if.sv
// Valid/ready stage handshake carrying the ID->EXE control and data bundles.
// The master drives valid/ctrl/data and the slave returns ready.
interface id_ex_elastic_reg_if #(
  parameter int CTRL_W = 8,
  parameter int DATA_W = 120
);
  logic              valid;
  logic              ready;
  logic [CTRL_W-1:0] ctrl;
  logic [DATA_W-1:0] data;

  modport master (output valid, output ctrl, output data, input ready);
  modport slave  (input valid, input ctrl, input data, output ready);
endinterface

// File: rtl/id_ex_elastic_reg.sv
// ID->EXE elastic pipeline register: main entry plus one skid entry, registered in_ready,
// synchronous flush and bubble-gated control bundle.
module id_ex_elastic_reg #(
  parameter int CTRL_W         = 8,
  parameter int DATA_W         = 120,
  parameter bit CLEAR_ON_FLUSH = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  id_ex_elastic_reg_if.slave   in_if,
  id_ex_elastic_reg_if.master  out_if,
  output logic [1:0]           occupancy
);

  localparam logic [1:0] EMPTY = 2'd0;
  localparam logic [1:0] ONE   = 2'd1;
  localparam logic [1:0] FULL  = 2'd2;

  logic [1:0]        state, next_state;
  logic              in_ready_q;
  logic [CTRL_W-1:0] main_ctrl, skid_ctrl;
  logic [DATA_W-1:0] main_data, skid_data;

  logic in_fire, out_fire;
  logic load_main_in, load_skid, load_main_skid;

  assign in_fire  = in_if.valid & in_ready_q;
  assign out_fire = (state != EMPTY) & out_if.ready;

  assign load_main_in   = in_fire & ((state == EMPTY) | ((state == ONE) & out_fire));
  assign load_skid      = in_fire & (state == ONE) & ~out_fire;
  assign load_main_skid = (state == FULL) & out_fire;

  always_comb begin
    next_state = state;
    case (state)
      EMPTY: if (in_fire) next_state = ONE;
      ONE: begin
        if (in_fire && !out_fire)      next_state = FULL;
        else if (!in_fire && out_fire) next_state = EMPTY;
      end
      FULL:  if (out_fire) next_state = ONE;
      default: next_state = EMPTY;
    endcase
    if (flush) next_state = EMPTY;
  end

  // in_ready is a flop computed from next_state, so there is no comb path from out_ready.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= EMPTY;
      in_ready_q <= 1'b1;
    end else begin
      state      <= next_state;
      in_ready_q <= (next_state != FULL);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      main_ctrl <= '0;
      skid_ctrl <= '0;
    end else if (flush) begin
      main_ctrl <= '0;
      skid_ctrl <= '0;
    end else begin
      if (load_main_in)        main_ctrl <= in_if.ctrl;
      else if (load_main_skid) main_ctrl <= skid_ctrl;
      if (load_skid)           skid_ctrl <= in_if.ctrl;
    end
  end

  // Data registers only clear on flush when configured to; otherwise they simply hold.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      main_data <= '0;
      skid_data <= '0;
    end else if (flush) begin
      if (CLEAR_ON_FLUSH) begin
        main_data <= '0;
        skid_data <= '0;
      end
    end else begin
      if (load_main_in)        main_data <= in_if.data;
      else if (load_main_skid) main_data <= skid_data;
      if (load_skid)           skid_data <= in_if.data;
    end
  end

  assign out_if.valid = (state != EMPTY);
  assign out_if.ctrl  = (state != EMPTY) ? main_ctrl : '0;
  assign out_if.data  = main_data;
  assign in_if.ready  = in_ready_q;
  assign occupancy    = state;

endmodule

// File: tb/tb_id_ex_elastic_reg.sv
// Bench for id_ex_elastic_reg: directed vector table, async reset mid-stream,
// and a random run checked against a reference queue.
module tb_id_ex_elastic_reg;

  localparam int CW = 8;
  localparam int DW = 120;

  logic       clk;
  logic       rst;
  logic       flush;
  logic [1:0] occupancy;

  id_ex_elastic_reg_if #(.CTRL_W(CW), .DATA_W(DW)) in_if ();
  id_ex_elastic_reg_if #(.CTRL_W(CW), .DATA_W(DW)) out_if ();

  id_ex_elastic_reg #(.CTRL_W(CW), .DATA_W(DW), .CLEAR_ON_FLUSH(1'b1)) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_if     (in_if.slave),
    .out_if    (out_if.master),
    .occupancy (occupancy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic          flush;
    logic          iv;
    logic [CW-1:0] ictrl;
    logic [DW-1:0] idata;
    logic          ordy;
    logic          e_ov;
    logic [CW-1:0] e_ctrl;
    logic [DW-1:0] e_data;
    logic [1:0]    e_occ;
    logic          e_irdy;
  } vec_t;

  typedef struct {
    logic [CW-1:0] ctrl;
    logic [DW-1:0] data;
  } entry_t;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  vec_t   tbl[23];
  entry_t sb[$];

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic fl, input logic iv, input logic [CW-1:0] ic,
                              input logic [DW-1:0] id, input logic ordy, input logic ov,
                              input logic [CW-1:0] oc, input logic [DW-1:0] od,
                              input logic [1:0] occ, input logic irdy);
    vec_t v;
    v.flush = fl; v.iv = iv; v.ictrl = ic; v.idata = id; v.ordy = ordy;
    v.e_ov = ov; v.e_ctrl = oc; v.e_data = od; v.e_occ = occ; v.e_irdy = irdy;
    return v;
  endfunction

  task automatic drive(input logic fl, input logic iv, input logic [CW-1:0] ic,
                       input logic [DW-1:0] id, input logic ordy);
    flush        = fl;
    in_if.valid  = iv;
    in_if.ctrl   = ic;
    in_if.data   = id;
    out_if.ready = ordy;
  endtask

  initial begin
    logic [127:0] r;
    logic         rfl, riv, rordy;
    logic [CW-1:0] rc;
    logic         in_fire, out_fire;
    entry_t       e;

    // Streaming: 1..8 back to back, then drain
    for (int i = 0; i < 8; i++)
      tbl[i] = mk(0, 1, CW'(8'h11 + i), DW'(i + 1), 1, 1, CW'(8'h11 + i), DW'(i + 1), 2'd1, 1);
    tbl[8]  = mk(0, 0, 8'h00, '0,     1, 0, 8'h00, DW'(8),  2'd0, 1);
    // Back-pressure: A, B fill, C held upstream until space
    tbl[9]  = mk(0, 1, 8'h21, 'hA,    0, 1, 8'h21, 'hA,     2'd1, 1);
    tbl[10] = mk(0, 1, 8'h22, 'hB,    0, 1, 8'h21, 'hA,     2'd2, 0);
    tbl[11] = mk(0, 1, 8'h23, 'hC,    0, 1, 8'h21, 'hA,     2'd2, 0);
    tbl[12] = mk(0, 1, 8'h23, 'hC,    1, 1, 8'h22, 'hB,     2'd1, 1);
    tbl[13] = mk(0, 1, 8'h23, 'hC,    1, 1, 8'h23, 'hC,     2'd1, 1);
    tbl[14] = mk(0, 0, 8'h00, '0,     1, 0, 8'h00, 'hC,     2'd0, 1);
    // Simultaneous IN & OUT while holding one entry
    tbl[15] = mk(0, 1, 8'h31, 'h31,   0, 1, 8'h31, 'h31,    2'd1, 1);
    tbl[16] = mk(0, 1, 8'hA5, 'hA5A5, 1, 1, 8'hA5, 'hA5A5,  2'd1, 1);
    // Flush while full with D presented
    tbl[17] = mk(0, 1, 8'h41, 'h41,   0, 1, 8'hA5, 'hA5A5,  2'd2, 0);
    tbl[18] = mk(1, 1, 8'h4D, 'h4D,   0, 0, 8'h00, '0,      2'd0, 1);
    tbl[19] = mk(0, 0, 8'h00, '0,     1, 0, 8'h00, '0,      2'd0, 1);
    tbl[20] = mk(0, 1, 8'h55, 'h55,   1, 1, 8'h55, 'h55,    2'd1, 1);
    tbl[21] = mk(1, 1, 8'h66, 'h66,   1, 0, 8'h00, '0,      2'd0, 1);
    // Unknown inputs with in_valid low must not reach out_ctrl
    tbl[22] = mk(0, 0, 'x,    'x,     1, 0, 8'h00, '0,      2'd0, 1);

    rst = 1'b1;
    drive(0, 0, '0, '0, 0);
    repeat (2) @(posedge clk);
    #1;
    chk("reset out_valid", DW'(out_if.valid), DW'(0));
    chk("reset out_ctrl",  DW'(out_if.ctrl),  DW'(0));
    chk("reset out_data",  out_if.data,       '0);
    chk("reset occupancy", DW'(occupancy),    DW'(0));
    chk("reset in_ready",  DW'(in_if.ready),  DW'(1));
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    for (int i = 0; i < 23; i++) begin
      drive(tbl[i].flush, tbl[i].iv, tbl[i].ictrl, tbl[i].idata, tbl[i].ordy);
      @(posedge clk);
      #1;
      chk($sformatf("v%0d out_valid", i), DW'(out_if.valid), DW'(tbl[i].e_ov));
      chk($sformatf("v%0d out_ctrl", i),  DW'(out_if.ctrl),  DW'(tbl[i].e_ctrl));
      chk($sformatf("v%0d out_data", i),  out_if.data,       tbl[i].e_data);
      chk($sformatf("v%0d occupancy", i), DW'(occupancy),    DW'(tbl[i].e_occ));
      chk($sformatf("v%0d in_ready", i),  DW'(in_if.ready),  DW'(tbl[i].e_irdy));
    end

    // Async reset while full
    drive(0, 1, 8'h77, 'h77, 0);
    @(posedge clk); #1;
    drive(0, 1, 8'h78, 'h78, 0);
    @(posedge clk); #1;
    chk("prefill occupancy", DW'(occupancy), DW'(2));
    drive(0, 0, '0, '0, 0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("async rst out_valid", DW'(out_if.valid), DW'(0));
    chk("async rst out_ctrl",  DW'(out_if.ctrl),  DW'(0));
    chk("async rst occupancy", DW'(occupancy),    DW'(0));
    #2;
    rst = 1'b0;
    @(posedge clk); #1;
    chk("post rst in_ready",  DW'(in_if.ready),  DW'(1));
    chk("post rst out_valid", DW'(out_if.valid), DW'(0));

    // Random traffic against the reference queue
    for (int c = 0; c < 10000; c++) begin
      rfl   = ($urandom_range(99) < 5);
      riv   = ($urandom_range(99) < 60);
      rordy = ($urandom_range(99) < 60);
      rc    = CW'($urandom);
      r     = {$urandom, $urandom, $urandom, $urandom};
      drive(rfl, riv, rc, r[DW-1:0], rordy);
      @(negedge clk);
      chk("rnd occupancy", DW'(occupancy),    DW'(sb.size()));
      chk("rnd in_ready",  DW'(in_if.ready),  DW'(sb.size() < 2));
      chk("rnd out_valid", DW'(out_if.valid), DW'(sb.size() > 0));
      if (sb.size() > 0) begin
        chk("rnd out_ctrl", DW'(out_if.ctrl), DW'(sb[0].ctrl));
        chk("rnd out_data", out_if.data,      sb[0].data);
      end else begin
        chk("rnd bubble ctrl", DW'(out_if.ctrl), DW'(0));
      end
      in_fire  = riv & (sb.size() < 2);
      out_fire = rordy & (sb.size() > 0);
      if (rfl) begin
        sb.delete();
      end else begin
        if (out_fire) void'(sb.pop_front());
        if (in_fire) begin
          e.ctrl = rc;
          e.data = r[DW-1:0];
          sb.push_back(e);
        end
      end
      @(posedge clk);
      #1;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
